// File: rtl/mem2wbk_fifo.sv
// mem2wbk_fifo: 2-entry MEM->WBK pipeline FIFO with registered head outputs.
// Define MEM2WBK_FLUSH_EN to add the synchronous MEM2WBK_FLUSH_SM input.
module mem2wbk_fifo (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MEM2WBK_FLUSH_EN
    input  logic        MEM2WBK_FLUSH_SM,
`endif
    input  logic [31:0] MEM_RES_SM,
    input  logic [5:0]  MEM_DEST_SM,
    input  logic        WB_SM,
    input  logic [31:0] PC_MEM2WBK_SM,
    input  logic [31:0] CSR_RDATA_SM,
    input  logic        CSR_WENABLE_SM,
    input  logic        MULT_INST_SM,
    input  logic        MEM2WBK_PUSH_SM,
    input  logic        MEM2WBK_POP_SW,
    output logic [31:0] MEM_RES_RM,
    output logic [5:0]  MEM_DEST_RM,
    output logic        WB_RM,
    output logic [31:0] PC_MEM2WBK_RM,
    output logic [31:0] CSR_RDATA_RM,
    output logic        CSR_WENABLE_RM,
    output logic        MULT_INST_RM,
    output logic        MEM2WBK_EMPTY_SM,
    output logic        MEM2WBK_FULL_SM
);
    logic [104:0] r_mem [2];
    logic         r_wptr, r_rptr;
    logic [1:0]   r_cnt;
    logic         w_push, w_pop, w_flush;
    logic [104:0] w_din, w_head;
`ifdef MEM2WBK_FLUSH_EN
    assign w_flush = MEM2WBK_FLUSH_SM;
`else
    assign w_flush = 1'b0;
`endif
    assign w_din  = {MEM_RES_SM, MEM_DEST_SM, WB_SM, PC_MEM2WBK_SM, CSR_RDATA_SM, CSR_WENABLE_SM, MULT_INST_SM};
    assign w_pop  = MEM2WBK_POP_SW && (r_cnt != 2'd0);
    // a same-cycle pop frees the slot, so a full FIFO can still accept
    assign w_push = MEM2WBK_PUSH_SM && ((r_cnt != 2'd2) || w_pop);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (w_flush) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_din;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
    assign w_head = r_mem[r_rptr];
    assign {MEM_RES_RM, MEM_DEST_RM, WB_RM, PC_MEM2WBK_RM, CSR_RDATA_RM, CSR_WENABLE_RM, MULT_INST_RM} = w_head;
    assign MEM2WBK_EMPTY_SM = (r_cnt == 2'd0);
    assign MEM2WBK_FULL_SM  = (r_cnt == 2'd2);
endmodule

// File: tb/tb_mem2wbk_fifo.sv
// tb_mem2wbk_fifo: queue-model scoreboard bench for mem2wbk_fifo.
// Define MEM2WBK_FLUSH_EN to also exercise the flush input.
module tb_mem2wbk_fifo;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         push = 1'b0, pop = 1'b0;
`ifdef MEM2WBK_FLUSH_EN
    logic         flush = 1'b0;
`endif
    logic [104:0] din = '0;
    logic [31:0]  mem_res_rm, pc_rm, csr_rdata_rm;
    logic [5:0]   dest_rm;
    logic         wb_rm, csr_we_rm, mult_rm, empty, full;
    logic [104:0] head;
    logic [104:0] q[$];
    bit           mon_en = 1'b0;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem2wbk_fifo dut (
        .clk(clk), .reset_n(reset_n),
`ifdef MEM2WBK_FLUSH_EN
        .MEM2WBK_FLUSH_SM(flush),
`endif
        .MEM_RES_SM(din[104:73]), .MEM_DEST_SM(din[72:67]), .WB_SM(din[66]),
        .PC_MEM2WBK_SM(din[65:34]), .CSR_RDATA_SM(din[33:2]), .CSR_WENABLE_SM(din[1]),
        .MULT_INST_SM(din[0]), .MEM2WBK_PUSH_SM(push), .MEM2WBK_POP_SW(pop),
        .MEM_RES_RM(mem_res_rm), .MEM_DEST_RM(dest_rm), .WB_RM(wb_rm), .PC_MEM2WBK_RM(pc_rm),
        .CSR_RDATA_RM(csr_rdata_rm), .CSR_WENABLE_RM(csr_we_rm), .MULT_INST_RM(mult_rm),
        .MEM2WBK_EMPTY_SM(empty), .MEM2WBK_FULL_SM(full)
    );
    assign head = {mem_res_rm, dest_rm, wb_rm, pc_rm, csr_rdata_rm, csr_we_rm, mult_rm};

    task automatic chk(input string n, input logic [104:0] a, input logic [104:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [104:0] rp();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[104:0];
    endfunction

    function automatic logic [104:0] mk(input logic [31:0] mr, input logic [5:0] ds);
        logic [104:0] p;
        p = rp();
        p[104:73] = mr;
        p[72:67]  = ds;
        p[66]     = 1'b1;
        return p;
    endfunction

    // Scoreboard monitor: occupancy flags every cycle, head data on each accepted pop.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("empty", 105'(empty), 105'(q.size() == 0));
            chk("full", 105'(full), 105'(q.size() == 2));
            if (pop && q.size() > 0) begin
                chk("head", head, q[0]);
                void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus; called and returns at posedge+1.
    task automatic cyc(input bit pu, input bit po, input bit fl, input logic [104:0] d);
        bit ok;
        ok = pu && !fl && (q.size() < 2 || (po && q.size() > 0));
        din = d; push = pu; pop = po;
`ifdef MEM2WBK_FLUSH_EN
        flush = fl;
`endif
        @(posedge clk);
        if (fl) q.delete();
        else if (ok) q.push_back(d);
        #1;
        push = 1'b0; pop = 1'b0;
`ifdef MEM2WBK_FLUSH_EN
        flush = 1'b0;
`endif
    endtask

    initial begin
        logic [104:0] a, b, c, d, e;
        bit fl;
        a = mk(32'h11111111, 6'd5);
        b = mk(32'h22222222, 6'd6);
        c = mk(32'h33333333, 6'd7);
        d = mk(32'h44444444, 6'd8);
        e = mk(32'h55555555, 6'd9);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_head", head, '0);
        chk("rst_empty", 105'(empty), 105'(1));
        chk("rst_full", 105'(full), 105'(0));
        reset_n = 1'b1;
        mon_en = 1'b1;
        cyc(1, 0, 0, a);
        chk("a_empty", 105'(empty), 105'(0));
        chk("a_full", 105'(full), 105'(0));
        chk("a_res", 105'(mem_res_rm), 105'(32'h11111111));
        chk("a_dest", 105'(dest_rm), 105'(5));
        cyc(1, 0, 0, b);
        chk("ab_full", 105'(full), 105'(1));
        cyc(1, 0, 0, c);
        cyc(0, 1, 0, rp());
        cyc(0, 1, 0, rp());
        chk("drained", 105'(empty), 105'(1));
        cyc(1, 0, 0, a);
        cyc(1, 0, 0, b);
        cyc(1, 1, 0, c);
        chk("pp_full", 105'(full), 105'(1));
        cyc(0, 1, 0, rp());
        cyc(0, 1, 0, rp());
        cyc(1, 1, 0, d);
        chk("d_empty", 105'(empty), 105'(0));
        chk("d_head", head, d);
        cyc(0, 1, 0, rp());
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, rp());
            chk("uf_empty", 105'(empty), 105'(1));
        end
        cyc(1, 0, 0, e);
        chk("e_head", head, e);
        cyc(1, 0, 0, a);
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mr_empty", 105'(empty), 105'(1));
        chk("mr_full", 105'(full), 105'(0));
        chk("mr_head", head, '0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(1, 1, 0, b);
        chk("post_rst_head", head, b);
`ifdef MEM2WBK_FLUSH_EN
        cyc(1, 0, 0, c);
        cyc(1, 0, 1, d);
        chk("fl_empty", 105'(empty), 105'(1));
`endif
        for (int i = 0; i < 600; i++) begin
            fl = 1'b0;
`ifdef MEM2WBK_FLUSH_EN
            fl = ($urandom % 25) == 0;
`endif
            cyc(($urandom % 3) != 0, ($urandom % 3) != 0, fl, rp());
        end
        for (int i = 0; i < 4 && q.size() > 0; i++) cyc(0, 1, 0, rp());
        chk("final_q", 105'(q.size()), 105'(0));
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem2wbk_fifo.md
MEM2WBK_FIFO -- requirements
Module: mem2wbk_fifo

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 MEM_RES_SM  in  32  MEM-stage result payload.
REQ-004 MEM_DEST_SM  in  6  destination register index.
REQ-005 WB_SM  in  1  write-back request flag.
REQ-006 PC_MEM2WBK_SM  in  32  PC of the instruction.
REQ-007 CSR_RDATA_SM / CSR_WENABLE_SM  in  32 / 1  CSR read data and CSR-select flag.
REQ-008 MULT_INST_SM  in  1  multiply-instruction flag.
REQ-009 MEM2WBK_PUSH_SM  in  1  push request from the MEM stage.
REQ-010 MEM2WBK_POP_SW  in  1  pop request from the write-back stage.
REQ-011 MEM_RES_RM, MEM_DEST_RM, WB_RM, PC_MEM2WBK_RM, CSR_RDATA_RM, CSR_WENABLE_RM, MULT_INST_RM  out  32,6,1,32,32,1,1  head-entry fields.
REQ-012 MEM2WBK_EMPTY_SM  out  1  FIFO holds no entries.
REQ-013 MEM2WBK_FULL_SM  out  1  FIFO holds 2 entries.

Function
REQ-014 Storage: 2 entries x 105-bit payload (the fields of REQ-003..REQ-008); 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
REQ-015 EMPTY = (count==0); FULL = (count==2); both decoded from registered count only, with no combinational path from PUSH or POP.
REQ-016 Head outputs are driven from entry[read pointer] with no input-to-output combinational path; when empty they show the last entry written (or zero after reset), and consumers gate on EMPTY.
REQ-017 Push accepted iff PUSH=1 and (FULL=0 or an accepted pop occurs in the same cycle); payload written at entry[write pointer]; write pointer toggles.
REQ-018 Pop accepted iff POP=1 and EMPTY=0; read pointer toggles; head advances on the next cycle.
REQ-019 Push while full with no pop: ignored; storage, pointers, and count are unchanged.
REQ-020 Pop while empty: ignored; no underflow, and count stays 0.
REQ-021 Push and pop in the same cycle while empty: push accepted, pop ignored; no bypass, so the entry is visible on outputs the next cycle.
REQ-022 Push and pop both accepted in the same cycle: count unchanged, both pointers toggle.
REQ-023 Count update: +1 for push only, -1 for pop only, 0 for both or neither.
REQ-024 Pointers wrap modulo 2; ordering is strictly first-in first-out.
REQ-025 Latency: 1 cycle from accepted push into an empty FIFO to EMPTY=0 with valid head outputs.

Reset
REQ-026 reset_n=0 asynchronously clears count, both pointers, and all storage to 0; EMPTY=1, FULL=0, and all head outputs 0.
REQ-027 Reset asserted mid-operation discards all entries; PUSH and POP in the first cycle after release behave as in an empty FIFO.

Configuration
REQ-028 Macro MEM2WBK_FLUSH_EN defined: adds input MEM2WBK_FLUSH_SM (1 bit).
REQ-029 When MEM2WBK_FLUSH_SM=1 at a clock edge, count and both pointers go to 0, and any same-cycle push and pop are discarded; EMPTY=1 the next cycle, and storage contents are not cleared.
REQ-030 Macro MEM2WBK_FLUSH_EN undefined: the flush port is absent, and all other behaviour is identical.

Verification
REQ-031 Reset, then push A (MEM_RES=0x11111111, DEST=5, WB=1) -> next cycle EMPTY=0, FULL=0, MEM_RES_RM=0x11111111, MEM_DEST_RM=5.
REQ-032 Push A, then push B (0x22222222), no pop -> FULL=1; a third push C is dropped; pop twice -> outputs A then B, then EMPTY=1.
REQ-033 Full, with push C and pop in the same cycle -> count stays 2; subsequent pops yield B then C.
REQ-034 Empty, with push D and pop in the same cycle -> next cycle EMPTY=0, head=D, count=1.
REQ-035 Pop on empty for 3 cycles -> EMPTY stays 1 and count stays 0; then push E -> head=E.
REQ-036 With two entries held, assert reset_n=0 mid-cycle -> EMPTY=1 and outputs 0 immediately; with MEM2WBK_FLUSH_EN defined, FLUSH=1 with push F -> next cycle EMPTY=1 and F discarded.
